// File: rtl/serial_operand_loader_if.sv
// serial_operand_loader_if: parallel operand handshake plus serial bit-pair stream
interface serial_operand_loader_if #(parameter int WIDTH = 4);
  logic in_valid, in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic bit_valid, bit_ready, bit_a, bit_b, bit_first, bit_last, busy;
  modport master (
    output in_valid, in_a, in_b, bit_ready,
    input  in_ready, bit_valid, bit_a, bit_b, bit_first, bit_last, busy
  );
  modport slave (
    input  in_valid, in_a, in_b, bit_ready,
    output in_ready, bit_valid, bit_a, bit_b, bit_first, bit_last, busy
  );
endinterface

// File: rtl/serial_operand_loader.sv
// serial_operand_loader: buffers one operand pair and streams pairs LSB-first as bit frames
module serial_operand_loader #(parameter int WIDTH = 4) (
  input logic clk,
  input logic reset,
  serial_operand_loader_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [WIDTH-1:0] sa, sb, pend_a, pend_b;
  logic [CW-1:0] cnt;
  logic pend_valid, acc, xfer, last;
  always_comb begin
    bus.in_ready = reset & ~pend_valid;
    bus.bit_valid = state == SHIFT;
    bus.bit_a = sa[0];
    bus.bit_b = sb[0];
    bus.bit_first = bus.bit_valid & (cnt == '0);
    bus.bit_last = bus.bit_valid & (cnt == LAST);
    bus.busy = bus.bit_valid | pend_valid;
    acc = bus.in_valid & bus.in_ready;
    xfer = bus.bit_valid & bus.bit_ready;
    last = xfer & bus.bit_last;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      sa <= '0;
      sb <= '0;
      pend_a <= '0;
      pend_b <= '0;
      pend_valid <= 1'b0;
    end else if (state == IDLE) begin
      if (acc) begin
        sa <= bus.in_a;
        sb <= bus.in_b;
        cnt <= '0;
        state <= SHIFT;
      end
    end else if (last) begin
      cnt <= '0;
      sa <= pend_valid ? pend_a : acc ? bus.in_a : '0;
      sb <= pend_valid ? pend_b : acc ? bus.in_b : '0;
      pend_valid <= 1'b0;
      if (!pend_valid && !acc) state <= IDLE;
    end else begin
      if (xfer) begin
        sa <= sa >> 1;
        sb <= sb >> 1;
        cnt <= cnt + 1'b1;
      end
      if (acc) begin
        pend_a <= bus.in_a;
        pend_b <= bus.in_b;
        pend_valid <= 1'b1;
      end
    end
endmodule

// File: doc/serial_operand_loader.md
Name: serial_operand_loader

Overview:
Upstream feeder for the bit-serial adder. Accepts parallel operand pairs over a valid/ready handshake, buffers one pair, and streams both operands LSB-first as bit pairs. Each frame carries a first-bit marker, used by the adder to clear its carry, and a last-bit marker. Back-to-back frames go out with no idle cycle between them.

Parameters:
WIDTH, 4, operand width in bits (WIDTH >= 2); also the bit count per serial frame.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  operand pair offered
in_ready  output  1  loader can accept a pair this cycle
in_a  input  WIDTH  operand A, parallel
in_b  input  WIDTH  operand B, parallel
bit_valid  output  1  bit_a/bit_b/markers valid
bit_ready  input  1  downstream adder consumes the current bit pair
bit_a  output  1  current bit of A (LSB first)
bit_b  output  1  current bit of B (LSB first)
bit_first  output  1  current pair is bit 0 of a frame (carry-clear)
bit_last  output  1  current pair is bit WIDTH-1 of a frame
busy  output  1  frame in flight or pair pending

Behaviour:
- State: FSM {IDLE, SHIFT}; shift registers sa, sb (WIDTH); bit counter cnt (clog2(WIDTH) bits); pending buffer pend_a, pend_b, pend_valid.
- Reset (reset=0, async): state=IDLE, cnt=0, sa=sb=0, pend_valid=0. While reset=0 all outputs are 0, including in_ready.
- in_ready = reset & !pend_valid (combinational).
- Input handshake: in_valid & in_ready sampled at the rising edge.
- bit_valid = (state==SHIFT); bit_a=sa[0]; bit_b=sb[0]; bit_first=(cnt==0)&bit_valid; bit_last=(cnt==WIDTH-1)&bit_valid.
- Bit transfer: bit_valid & bit_ready at the edge. Shift sa, sb right by one (zero fill); cnt++.
- While bit_ready=0, all bit_* outputs are held stable and no state changes.
- IDLE + input handshake: load sa/sb directly, cnt=0, go to SHIFT. First bit is valid in the cycle after the handshake edge (latency 1).
- SHIFT + input handshake that is not on a last-bit transfer: capture into the pending buffer, pend_valid=1.
- Last-bit transfer (bit_valid & bit_ready & bit_last), resolved in priority order:
  1. pend_valid=1: load sa/sb from pend, clear pend_valid, cnt=0, stay in SHIFT. No bubble.
  2. Else, input handshake in the same cycle: load sa/sb directly from in_a/in_b, cnt=0, stay in SHIFT. No bubble.
  3. Else: go to IDLE, cnt=0.
- Full condition: pend_valid=1 during SHIFT forces in_ready=0, so at most 2 pairs are in the block.
- busy = (state==SHIFT) | pend_valid.
- Reset mid-frame: frame and pending pair are discarded immediately. After reset=1, the first edge sees in_ready=1 and bit_valid=0.
- in_valid asserted while in_ready=0: ignored. The source must hold its data.

Test Plan:
1. Basic frame: reset low 20 time units then high; in_a=4'b1111, in_b=4'b1111, one-cycle handshake, bit_ready=1.
   -> Next 4 cycles: bit_a=bit_b=1; bit_first on cycle 1; bit_last on cycle 4.
   -> Cycle 5: bit_valid=0, busy=0.
2. Bit order: in_a=4'b0101, in_b=4'b0011.
   -> bit_a sequence 1,0,1,0; bit_b sequence 1,1,0,0; markers on bits 0 and 3.
3. Backpressure: hold bit_ready=0 for 3 cycles at cnt=2 of in_a=4'b1001.
   -> bit_a stays 0 and bit_last stays 0 throughout the stall.
   -> After release, the remaining bits are 0,1. Total 4 transfers, none lost or duplicated.
4. Back-to-back: offer pair 2 (0110/0001) during frame 1, then pair 3.
   -> Pair 2 is accepted; in_ready=0 and pair 3 stalls until frame 1's last-bit transfer.
   -> Frame 2 bit_first appears the cycle after frame 1 bit_last. busy stays high throughout.
5. Async reset mid-frame: drop reset after 2 bits with a pair pending.
   -> bit_valid and in_ready go 0 without waiting for a clock edge.
   -> After release: busy=0, in_ready=1, and no stale bits are emitted.
6. WIDTH=8: in_a=8'hA5, in_b=8'h3C.
   -> bit_a sequence 1,0,1,0,0,1,0,1; bit_b sequence 0,0,1,1,1,1,0,0; bit_last on the 8th transfer.
